// File: rtl/scan_ctrl_pkg.sv
// Shared types for the scan shift sequencer: FSM state encoding and phase-counter sizing.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        DECIDE,
        UNLOAD
    } scan_state_t;

    // One counter serves both the shift and capture phases, so size it for the longer one.
    function automatic int cnt_width(input int width, input int cap_cycles);
        int n;
        n = (width > cap_cycles) ? width : cap_cycles;
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/scan_bit_counter.sv
// Phase length down-counter: load N-1 on phase entry, decrement per cycle, terminal count at zero.
module scan_bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_tc
);

    logic [CW-1:0] r_count;

    // Holds at zero rather than wrapping if a phase lingers past terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/scan_shift_ctrl.sv
// Scan-chain sequencer: shifts patterns in, pulses capture, unloads responses overlapped with the next load.
// Define SCAN_CTRL_COMPARE_EN to add exp_data/rsp_fail response checking.
//
//   state   | meaning
//   IDLE    | no operation; waiting for a pattern
//   SHIFT   | shifting a pattern in, previous response out
//   CAPTURE | capture strobe held for CAPTURE_CYCLES
//   DECIDE  | chain frozen; take next pattern or start unload
//   UNLOAD  | shifting the last response out with zero fill
module scan_shift_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int CAPTURE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [WIDTH-1:0] pat_data,
    input  logic             scan_so,
    output logic             chain_en,
    output logic             scan_en,
    output logic             scan_si,
    output logic             capture_en,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
`ifdef SCAN_CTRL_COMPARE_EN
    input  logic [WIDTH-1:0] exp_data,
    output logic             rsp_fail,
`endif
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH, CAPTURE_CYCLES);

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_rsp_shift;
    logic [WIDTH-1:0] r_rsp_data;
    logic [WIDTH-1:0] w_rsp_next;
    logic             r_rsp_valid;
    logic             r_first_load;
    logic             w_slot_free;
    logic             w_accept;
    logic             w_tc;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic [CW-1:0]    w_cnt_val;
    logic             w_shifting;
    logic             w_rsp_set;

    assign w_slot_free = !r_rsp_valid || rsp_ready;
    assign pat_ready   = ((r_state == IDLE) || (r_state == DECIDE)) && w_slot_free;
    assign w_accept    = pat_valid && pat_ready;
    assign w_shifting  = (r_state == SHIFT) || (r_state == UNLOAD);
    assign w_rsp_next  = {r_rsp_shift[WIDTH-2:0], scan_so};
    // The first load after idle shifts out stale chain contents, so no response is produced.
    assign w_rsp_set   = w_tc && (((r_state == SHIFT) && !r_first_load) || (r_state == UNLOAD));

    scan_bit_counter #(
        .CW(CW)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        chain_en    = 1'b0;
        scan_en     = 1'b0;
        scan_si     = 1'b0;
        capture_en  = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = CW'(WIDTH - 1);
                end
            end
            SHIFT: begin
                chain_en  = 1'b1;
                scan_en   = 1'b1;
                scan_si   = r_shift[WIDTH-1];
                w_cnt_dec = 1'b1;
                if (w_tc) begin
                    w_state_nxt = CAPTURE;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = CW'(CAPTURE_CYCLES - 1);
                end
            end
            CAPTURE: begin
                chain_en   = 1'b1;
                capture_en = 1'b1;
                w_cnt_dec  = 1'b1;
                if (w_tc) begin
                    w_state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = CW'(WIDTH - 1);
                end else if (w_slot_free && !pat_valid) begin
                    w_state_nxt = UNLOAD;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = CW'(WIDTH - 1);
                end
            end
            UNLOAD: begin
                chain_en  = 1'b1;
                scan_en   = 1'b1;
                w_cnt_dec = 1'b1;
                if (w_tc) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_rsp_shift  <= '0;
            r_rsp_data   <= '0;
            r_rsp_valid  <= 1'b0;
            r_first_load <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_shift <= pat_data;
            end else if (w_shifting) begin
                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            end
            if (w_shifting) begin
                r_rsp_shift <= w_rsp_next;
            end
            if (w_rsp_set) begin
                r_rsp_data  <= w_rsp_next;
                r_rsp_valid <= 1'b1;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            if ((r_state == SHIFT) && w_tc) begin
                r_first_load <= 1'b0;
            end else if ((r_state == UNLOAD) && w_tc) begin
                r_first_load <= 1'b1;
            end
        end
    end

`ifdef SCAN_CTRL_COMPARE_EN
    logic [WIDTH-1:0] r_exp_pend;
    logic [WIDTH-1:0] r_exp_cmp;
    logic             r_rsp_fail;

    // exp_cmp tracks the pattern whose response is currently in the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp_pend <= '0;
            r_exp_cmp  <= '0;
            r_rsp_fail <= 1'b0;
        end else begin
            if ((r_state == DECIDE) && (w_accept || (w_state_nxt == UNLOAD))) begin
                r_exp_cmp <= r_exp_pend;
            end
            if (w_accept) begin
                r_exp_pend <= exp_data;
            end
            if (w_rsp_set) begin
                r_rsp_fail <= (w_rsp_next != r_exp_cmp);
            end
        end
    end

    assign rsp_fail = r_rsp_fail;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_scan_shift_ctrl.sv
// Directed bench for scan_shift_ctrl: behavioural inverting chain models around a 4-stage and an 8-stage instance.
`timescale 1ns/1ps
module tb_scan_shift_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_checks = 0;
    int         n_fail = 0;

    logic       pat_valid = 1'b0;
    logic       pat_ready;
    logic [3:0] pat_data = '0;
    logic       scan_so;
    logic       chain_en, scan_en, scan_si, capture_en;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       busy;
    logic [3:0] chain4 = '0;

    logic       pv8 = 1'b0;
    logic       pr8;
    logic [7:0] pd8 = '0;
    logic       so8;
    logic       ce8, se8, si8, cap8;
    logic       rv8;
    logic       rr8 = 1'b0;
    logic [7:0] rd8;
    logic       busy8;
    logic [7:0] chain8 = '0;
    int         n_se8 = 0;
    int         n_cap8 = 0;

`ifdef SCAN_CTRL_COMPARE_EN
    logic [3:0] exp_data = '0;
    logic       rsp_fail;
    logic [7:0] exp8 = '0;
    logic       rsp_fail8;
`endif

    always #5 clk = ~clk;

    scan_shift_ctrl #(.WIDTH(4), .CAPTURE_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_data(pat_data),
        .scan_so(scan_so), .chain_en(chain_en), .scan_en(scan_en), .scan_si(scan_si),
        .capture_en(capture_en), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef SCAN_CTRL_COMPARE_EN
        .exp_data(exp_data), .rsp_fail(rsp_fail),
`endif
        .busy(busy)
    );

    scan_shift_ctrl #(.WIDTH(8), .CAPTURE_CYCLES(3)) u_dut8 (
        .clk(clk), .rst(rst), .pat_valid(pv8), .pat_ready(pr8), .pat_data(pd8),
        .scan_so(so8), .chain_en(ce8), .scan_en(se8), .scan_si(si8),
        .capture_en(cap8), .rsp_valid(rv8), .rsp_ready(rr8), .rsp_data(rd8),
`ifdef SCAN_CTRL_COMPARE_EN
        .exp_data(exp8), .rsp_fail(rsp_fail8),
`endif
        .busy(busy8)
    );

    // Chain models: shift from stage 0 toward the tail, capture stores the inverted contents.
    always @(posedge clk) begin
        if (chain_en && scan_en) chain4 <= {chain4[2:0], scan_si};
        else if (chain_en && capture_en) chain4 <= ~chain4;
        if (ce8 && se8) chain8 <= {chain8[6:0], si8};
        else if (ce8 && cap8) chain8 <= ~chain8;
    end
    assign scan_so = chain4[3];
    assign so8     = chain8[7];

    always @(negedge clk) begin
        if (se8) n_se8++;
        if (cap8) n_cap8++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({chain_en, scan_en, scan_si, capture_en, rsp_valid, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 000000", {chain_en, scan_en, scan_si, capture_en, rsp_valid, busy});
        end
        n_checks++;
        if (rsp_data !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_rsp_data got %b want 0000", rsp_data);
        end
        n_checks++;
        if (pat_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pat_ready got %b want 1", pat_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single(input logic [3:0] pat, input logic [3:0] rsp, input string tag);
        pat_valid = 1'b1;
        pat_data  = pat;
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if ({pat_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s idle_ready got %b want 10", tag, {pat_ready, busy});
        end
        @(negedge clk);
        pat_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({chain_en, scan_en, capture_en, scan_si, rsp_valid} !== {3'b110, pat[3-i], 1'b0}) begin
                n_fail++;
                $display("FAIL %s shift%0d got %b want %b", tag, i, {chain_en, scan_en, capture_en, scan_si, rsp_valid}, {3'b110, pat[3-i], 1'b0});
            end
            @(negedge clk);
        end
        n_checks++;
        if ({chain_en, scan_en, capture_en, rsp_valid} !== 4'b1010) begin
            n_fail++;
            $display("FAIL %s capture got %b want 1010", tag, {chain_en, scan_en, capture_en, rsp_valid});
        end
        @(negedge clk);
        n_checks++;
        if ({busy, chain_en, scan_en, capture_en, pat_ready} !== 5'b10001) begin
            n_fail++;
            $display("FAIL %s decide got %b want 10001", tag, {busy, chain_en, scan_en, capture_en, pat_ready});
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({chain_en, scan_en, capture_en, scan_si, rsp_valid} !== 5'b11000) begin
                n_fail++;
                $display("FAIL %s unload%0d got %b want 11000", tag, i, {chain_en, scan_en, capture_en, scan_si, rsp_valid});
            end
            @(negedge clk);
        end
        n_checks++;
        if ({rsp_valid, busy, rsp_data} !== {2'b10, rsp}) begin
            n_fail++;
            $display("FAIL %s response got %b want %b", tag, {rsp_valid, busy, rsp_data}, {2'b10, rsp});
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s rsp_valid_drop got %b want 0", tag, rsp_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] b;
        b = 4'b0110;
        pat_valid = 1'b1;
        pat_data  = 4'b1011;
        rsp_ready = 1'b1;
`ifdef SCAN_CTRL_COMPARE_EN
        exp_data = 4'b0100;
`endif
        @(negedge clk);
        pat_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({busy, chain_en, pat_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL b2b_decide got %b want 101", {busy, chain_en, pat_ready});
        end
        pat_valid = 1'b1;
        pat_data  = b;
`ifdef SCAN_CTRL_COMPARE_EN
        exp_data = 4'b0101;
`endif
        @(negedge clk);
        pat_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({scan_en, capture_en, scan_si} !== {2'b10, b[3-i]}) begin
                n_fail++;
                $display("FAIL b2b_shift%0d got %b want %b", i, {scan_en, capture_en, scan_si}, {2'b10, b[3-i]});
            end
            @(negedge clk);
        end
        n_checks++;
        if ({capture_en, rsp_valid, rsp_data} !== 6'b110100) begin
            n_fail++;
            $display("FAIL b2b_first_rsp got %b want 110100", {capture_en, rsp_valid, rsp_data});
        end
`ifdef SCAN_CTRL_COMPARE_EN
        n_checks++;
        if (rsp_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_match rsp_fail got %b want 0", rsp_fail);
        end
`endif
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, chain_en, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL b2b_decide2 got %b want 001", {rsp_valid, chain_en, busy});
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({scan_en, scan_si} !== 2'b10) begin
                n_fail++;
                $display("FAIL b2b_unload%0d got %b want 10", i, {scan_en, scan_si});
            end
            @(negedge clk);
        end
        n_checks++;
        if ({rsp_valid, busy, rsp_data} !== 6'b101001) begin
            n_fail++;
            $display("FAIL b2b_last_rsp got %b want 101001", {rsp_valid, busy, rsp_data});
        end
`ifdef SCAN_CTRL_COMPARE_EN
        n_checks++;
        if (rsp_fail !== 1'b1) begin
            n_fail++;
            $display("FAIL cmp_mismatch rsp_fail got %b want 1", rsp_fail);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        pat_valid = 1'b1;
        pat_data  = 4'b1011;
        rsp_ready = 1'b1;
        @(negedge clk);
        pat_valid = 1'b0;
        repeat (5) @(negedge clk);
        pat_valid = 1'b1;
        pat_data  = 4'b0110;
        @(negedge clk);
        pat_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (5) @(negedge clk);
        pat_valid = 1'b1;
        pat_data  = 4'b1100;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({busy, chain_en, scan_en, capture_en, pat_ready, rsp_valid, rsp_data} !== 10'b1000010100) begin
                n_fail++;
                $display("FAIL bp_stall%0d got %b want 1000010100", i, {busy, chain_en, scan_en, capture_en, pat_ready, rsp_valid, rsp_data});
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (pat_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release pat_ready got %b want 1", pat_ready);
        end
        @(negedge clk);
        pat_valid = 1'b0;
        n_checks++;
        if ({scan_en, scan_si, rsp_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL bp_resume got %b want 110", {scan_en, scan_si, rsp_valid});
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if ({capture_en, rsp_valid, rsp_data} !== 6'b111001) begin
            n_fail++;
            $display("FAIL bp_second_rsp got %b want 111001", {capture_en, rsp_valid, rsp_data});
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if ({rsp_valid, busy, rsp_data} !== 6'b100011) begin
            n_fail++;
            $display("FAIL bp_third_rsp got %b want 100011", {rsp_valid, busy, rsp_data});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift;
        pat_valid = 1'b1;
        pat_data  = 4'b1011;
        rsp_ready = 1'b1;
        @(negedge clk);
        pat_valid = 1'b0;
        repeat (5) @(negedge clk);
        pat_valid = 1'b1;
        pat_data  = 4'b0110;
        @(negedge clk);
        pat_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, scan_en} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_pre got %b want 11", {busy, scan_en});
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({chain_en, scan_en, scan_si, capture_en, rsp_valid, busy, rsp_data} !== 10'b0) begin
            n_fail++;
            $display("FAIL rst_mid got %b want 0000000000", {chain_en, scan_en, scan_si, capture_en, rsp_valid, busy, rsp_data});
        end
        n_checks++;
        if (pat_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pat_ready got %b want 1", pat_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        test_single(4'b1011, 4'b0100, "post_rst");
    endtask

    task automatic test_wide;
        logic [7:0] p;
        p   = 8'hA5;
        pv8 = 1'b1;
        pd8 = p;
        rr8 = 1'b1;
`ifdef SCAN_CTRL_COMPARE_EN
        exp8 = 8'h5A;
`endif
        #1;
        n_checks++;
        if (pr8 !== 1'b1) begin
            n_fail++;
            $display("FAIL wide_ready got %b want 1", pr8);
        end
        @(negedge clk);
        pv8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({ce8, se8, cap8, si8} !== {3'b110, p[7-i]}) begin
                n_fail++;
                $display("FAIL wide_shift%0d got %b want %b", i, {ce8, se8, cap8, si8}, {3'b110, p[7-i]});
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({ce8, se8, cap8} !== 3'b101) begin
                n_fail++;
                $display("FAIL wide_capture%0d got %b want 101", i, {ce8, se8, cap8});
            end
            @(negedge clk);
        end
        n_checks++;
        if ({busy8, ce8, cap8} !== 3'b100) begin
            n_fail++;
            $display("FAIL wide_decide got %b want 100", {busy8, ce8, cap8});
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({se8, si8, cap8} !== 3'b100) begin
                n_fail++;
                $display("FAIL wide_unload%0d got %b want 100", i, {se8, si8, cap8});
            end
            @(negedge clk);
        end
        n_checks++;
        if ({rv8, busy8, rd8} !== {2'b10, 8'h5A}) begin
            n_fail++;
            $display("FAIL wide_rsp got %b want %b", {rv8, busy8, rd8}, {2'b10, 8'h5A});
        end
`ifdef SCAN_CTRL_COMPARE_EN
        n_checks++;
        if (rsp_fail8 !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_cmp rsp_fail got %b want 0", rsp_fail8);
        end
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if (n_se8 !== 16) begin
            n_fail++;
            $display("FAIL wide_scan_en_total got %0d want 16", n_se8);
        end
        n_checks++;
        if (n_cap8 !== 3) begin
            n_fail++;
            $display("FAIL wide_capture_total got %0d want 3", n_cap8);
        end
    endtask

    initial begin
        test_reset();
        test_single(4'b1011, 4'b0100, "single");
        test_back_to_back();
        test_backpressure();
        test_reset_mid_shift();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
